// File: rtl/id_stage_pipelined_if.sv
// Bus between the IF/ID register, the decode stage and its consumers.
// The master drives decode inputs; the slave (decode stage) drives the ID/EXE fields.
interface id_stage_pipelined_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4,
  parameter int CNT_W   = 16
);
  logic [31:0]        instruction_in;
  logic [DATA_W-1:0]  pc_in;
  logic               valid_in;
  logic               freeze;
  logic               flush;
  logic               hazard;
  logic               status_n;
  logic               status_z;
  logic               status_c;
  logic               status_v;
  logic               wb_en_wb;
  logic [RADDR_W-1:0] dest_wb;
  logic [DATA_W-1:0]  result_wb;

  logic [RADDR_W-1:0] src1;
  logic [RADDR_W-1:0] src2;
  logic               two_src;
  logic               valid_out;
  logic               wb_en;
  logic               mem_r_en;
  logic               mem_w_en;
  logic               b;
  logic               s;
  logic [3:0]         exe_cmd;
  logic [DATA_W-1:0]  val_rn;
  logic [DATA_W-1:0]  val_rm;
  logic               imm;
  logic [11:0]        shift_operand;
  logic [23:0]        signed_imm_24;
  logic [RADDR_W-1:0] dest;
  logic [DATA_W-1:0]  pc_out;
  logic [CNT_W-1:0]   bubble_cnt;

  modport master (
    output instruction_in, pc_in, valid_in, freeze, flush, hazard,
           status_n, status_z, status_c, status_v, wb_en_wb, dest_wb, result_wb,
    input  src1, src2, two_src, valid_out, wb_en, mem_r_en, mem_w_en, b, s,
           exe_cmd, val_rn, val_rm, imm, shift_operand, signed_imm_24, dest,
           pc_out, bubble_cnt
  );

  modport slave (
    input  instruction_in, pc_in, valid_in, freeze, flush, hazard,
           status_n, status_z, status_c, status_v, wb_en_wb, dest_wb, result_wb,
    output src1, src2, two_src, valid_out, wb_en, mem_r_en, mem_w_en, b, s,
           exe_cmd, val_rn, val_rm, imm, shift_operand, signed_imm_24, dest,
           pc_out, bubble_cnt
  );
endinterface

// File: rtl/id_stage_pipelined.sv
// ARM decode stage: control decode, condition check, register file with
// write-through bypass, and the ID/EXE register with freeze, flush and bubbles.
module id_stage_pipelined #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4,
  parameter int CNT_W   = 16
) (
  input logic                 clk,
  input logic                 rst,
  id_stage_pipelined_if.slave bus
);
  localparam int NREG = 2 ** RADDR_W;
  localparam logic [RADDR_W-1:0] PC_IDX  = {RADDR_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

  function automatic logic cond_pass(input logic [3:0] cond, input logic n,
                                     input logic z, input logic c, input logic v);
    logic pass;
    case (cond)
      4'h0:    pass = z;
      4'h1:    pass = ~z;
      4'h2:    pass = c;
      4'h3:    pass = ~c;
      4'h4:    pass = n;
      4'h5:    pass = ~n;
      4'h6:    pass = v;
      4'h7:    pass = ~v;
      4'h8:    pass = c & ~z;
      4'h9:    pass = ~c | z;
      4'ha:    pass = (n == v);
      4'hb:    pass = (n != v);
      4'hc:    pass = ~z & (n == v);
      4'hd:    pass = z | (n != v);
      4'he:    pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  logic [31:0]       ins_s;
  logic [3:0]        opcode_s;
  logic [1:0]        mode_s;
  logic              s_bit_s;
  logic [3:0]        exe_cmd_s;
  logic              wb_en_s, mem_r_en_s, mem_w_en_s, b_s, s_s;
  logic              cond_ok_s;
  logic [RADDR_W-1:0] src1_s, src2_s;
  logic [DATA_W-1:0] val_rn_s, val_rm_s;

  logic [DATA_W-1:0] rf_r [NREG];

  // ctrl_r packs {exe_cmd, wb_en, mem_r_en, mem_w_en, b, s}
  logic [8:0]         ctrl_r;
  logic               valid_out_r;
  logic [DATA_W-1:0]  val_rn_r, val_rm_r, pc_out_r;
  logic               imm_r;
  logic [11:0]        shift_operand_r;
  logic [23:0]        signed_imm_24_r;
  logic [RADDR_W-1:0] dest_r;
  logic [CNT_W-1:0]   bubble_cnt_r;

  assign ins_s     = bus.instruction_in;
  assign opcode_s  = ins_s[24:21];
  assign mode_s    = ins_s[27:26];
  assign s_bit_s   = ins_s[20];
  assign cond_ok_s = cond_pass(ins_s[31:28], bus.status_n, bus.status_z,
                               bus.status_c, bus.status_v);

  // Control-unit mapping from mode/opcode/S to EXE command and enables
  always_comb begin
    exe_cmd_s  = 4'b0000;
    wb_en_s    = 1'b0;
    mem_r_en_s = 1'b0;
    mem_w_en_s = 1'b0;
    b_s        = 1'b0;
    s_s        = 1'b0;
    case (mode_s)
      2'b00: begin
        s_s = s_bit_s;
        case (opcode_s)
          4'b1101: begin exe_cmd_s = 4'b0001; wb_en_s = 1'b1; end
          4'b1111: begin exe_cmd_s = 4'b1001; wb_en_s = 1'b1; end
          4'b0100: begin exe_cmd_s = 4'b0010; wb_en_s = 1'b1; end
          4'b0101: begin exe_cmd_s = 4'b0011; wb_en_s = 1'b1; end
          4'b0010: begin exe_cmd_s = 4'b0100; wb_en_s = 1'b1; end
          4'b0110: begin exe_cmd_s = 4'b0101; wb_en_s = 1'b1; end
          4'b0000: begin exe_cmd_s = 4'b0110; wb_en_s = 1'b1; end
          4'b1100: begin exe_cmd_s = 4'b0111; wb_en_s = 1'b1; end
          4'b0001: begin exe_cmd_s = 4'b1000; wb_en_s = 1'b1; end
          4'b1010: begin exe_cmd_s = 4'b0100; end
          4'b1000: begin exe_cmd_s = 4'b0110; end
          default: begin exe_cmd_s = 4'b0000; end
        endcase
      end
      2'b01: begin
        exe_cmd_s = 4'b0010;
        if (s_bit_s) begin
          mem_r_en_s = 1'b1;
          wb_en_s    = 1'b1;
        end else begin
          mem_w_en_s = 1'b1;
        end
      end
      2'b10:   b_s = 1'b1;
      default: b_s = 1'b0;
    endcase
  end

  assign src1_s      = RADDR_W'(ins_s[19:16]);
  assign src2_s      = mem_w_en_s ? RADDR_W'(ins_s[15:12]) : RADDR_W'(ins_s[3:0]);
  assign bus.src1    = src1_s;
  assign bus.src2    = src2_s;
  assign bus.two_src = ~ins_s[25] | mem_w_en_s;

  // Register read: PC alias first, then write-back bypass, then storage
  always_comb begin
    if (src1_s == PC_IDX) begin
      val_rn_s = bus.pc_in + DATA_W'(4);
    end else if (bus.wb_en_wb && (bus.dest_wb == src1_s)) begin
      val_rn_s = bus.result_wb;
    end else begin
      val_rn_s = rf_r[src1_s];
    end
    if (src2_s == PC_IDX) begin
      val_rm_s = bus.pc_in + DATA_W'(4);
    end else if (bus.wb_en_wb && (bus.dest_wb == src2_s)) begin
      val_rm_s = bus.result_wb;
    end else begin
      val_rm_s = rf_r[src2_s];
    end
  end

  // Register-file storage; the PC index is never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_r[i] <= '0;
    end else if (bus.wb_en_wb && (bus.dest_wb != PC_IDX)) begin
      rf_r[bus.dest_wb] <= bus.result_wb;
    end
  end

  // ID/EXE register: flush beats freeze, freeze beats bubble/annul/capture
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_r          <= '0;
      valid_out_r     <= 1'b0;
      val_rn_r        <= '0;
      val_rm_r        <= '0;
      imm_r           <= 1'b0;
      shift_operand_r <= '0;
      signed_imm_24_r <= '0;
      dest_r          <= '0;
      pc_out_r        <= '0;
      bubble_cnt_r    <= '0;
    end else if (bus.flush) begin
      ctrl_r      <= '0;
      valid_out_r <= 1'b0;
    end else if (!bus.freeze) begin
      val_rn_r        <= val_rn_s;
      val_rm_r        <= val_rm_s;
      imm_r           <= ins_s[25];
      shift_operand_r <= ins_s[11:0];
      signed_imm_24_r <= ins_s[23:0];
      dest_r          <= RADDR_W'(ins_s[15:12]);
      pc_out_r        <= bus.pc_in;
      if (bus.hazard || !bus.valid_in) begin
        ctrl_r      <= '0;
        valid_out_r <= 1'b0;
        if (bus.hazard && (bubble_cnt_r != CNT_MAX)) begin
          bubble_cnt_r <= bubble_cnt_r + CNT_W'(1);
        end
      end else begin
        valid_out_r <= 1'b1;
        ctrl_r      <= cond_ok_s ? {exe_cmd_s, wb_en_s, mem_r_en_s, mem_w_en_s, b_s, s_s}
                                 : 9'b0;
      end
    end
  end

  assign bus.exe_cmd       = ctrl_r[8:5];
  assign bus.wb_en         = ctrl_r[4];
  assign bus.mem_r_en      = ctrl_r[3];
  assign bus.mem_w_en      = ctrl_r[2];
  assign bus.b             = ctrl_r[1];
  assign bus.s             = ctrl_r[0];
  assign bus.valid_out     = valid_out_r;
  assign bus.val_rn        = val_rn_r;
  assign bus.val_rm        = val_rm_r;
  assign bus.imm           = imm_r;
  assign bus.shift_operand = shift_operand_r;
  assign bus.signed_imm_24 = signed_imm_24_r;
  assign bus.dest          = dest_r;
  assign bus.pc_out        = pc_out_r;
  assign bus.bubble_cnt    = bubble_cnt_r;
endmodule

// File: tb/tb_id_stage_pipelined.sv
// Self-checking bench for id_stage_pipelined: directed scenarios plus a
// randomized run against an instruction-level reference model.
module tb_id_stage_pipelined;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  id_stage_pipelined_if #(.DATA_W(32), .RADDR_W(4), .CNT_W(16)) bus ();
  id_stage_pipelined_if #(.DATA_W(32), .RADDR_W(4), .CNT_W(2))  bus2 ();

  id_stage_pipelined #(.DATA_W(32), .RADDR_W(4), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  id_stage_pipelined #(.DATA_W(32), .RADDR_W(4), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data-processing opcode -> {exe_cmd, writes back}
  localparam logic [3:0] DP_EXE [16] = '{4'b0110, 4'b1000, 4'b0100, 4'b0000,
                                         4'b0010, 4'b0011, 4'b0101, 4'b0000,
                                         4'b0110, 4'b0000, 4'b0100, 4'b0000,
                                         4'b0111, 4'b0001, 4'b0000, 4'b1001};
  localparam bit DP_WB [16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  logic [31:0] m_regs [16];

  // Returns {exe_cmd, wb_en, mem_r_en, mem_w_en, b, s}
  function automatic logic [8:0] m_decode(input logic [31:0] ins);
    logic [8:0] r;
    r = 9'b0;
    if (ins[27:26] == 2'b00)
      r = {DP_EXE[ins[24:21]], DP_WB[ins[24:21]], 1'b0, 1'b0, 1'b0, ins[20]};
    else if (ins[27:26] == 2'b01)
      r = {4'b0010, ins[20], ins[20], ~ins[20], 1'b0, 1'b0};
    else if (ins[27:26] == 2'b10)
      r = 9'b0000_0001_0;
    return r;
  endfunction

  function automatic bit m_cond(input logic [3:0] c, input bit n, input bit z,
                                input bit cf, input bit v);
    bit base;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return (c[0] == 1'b0);
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a, input logic [31:0] pc,
                                         input bit wb, input logic [3:0] wd,
                                         input logic [31:0] wv);
    if (a == 4'd15) return pc + 32'd4;
    if (wb && a == wd) return wv;
    return m_regs[a];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.instruction_in = 32'h0; bus.pc_in = 32'h0; bus.valid_in = 1'b0;
    bus.freeze = 1'b0; bus.flush = 1'b0; bus.hazard = 1'b0;
    bus.status_n = 1'b0; bus.status_z = 1'b0; bus.status_c = 1'b0; bus.status_v = 1'b0;
    bus.wb_en_wb = 1'b0; bus.dest_wb = 4'd0; bus.result_wb = 32'h0;
  endtask

  task automatic test_reset();
    idle();
    bus2.instruction_in = 32'h0; bus2.pc_in = 32'h0; bus2.valid_in = 1'b0;
    bus2.freeze = 1'b0; bus2.flush = 1'b0; bus2.hazard = 1'b0;
    bus2.status_n = 1'b0; bus2.status_z = 1'b0; bus2.status_c = 1'b0; bus2.status_v = 1'b0;
    bus2.wb_en_wb = 1'b0; bus2.dest_wb = 4'd0; bus2.result_wb = 32'h0;
    bus.hazard = 1'b1; bus.valid_in = 1'b1; bus.instruction_in = 32'hE0821003;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({bus.valid_out, bus.exe_cmd, bus.wb_en, bus.mem_r_en, bus.mem_w_en, bus.b, bus.s} !== 10'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0", {bus.valid_out, bus.exe_cmd, bus.wb_en});
    end
    checks++;
    if ({bus.val_rn, bus.val_rm, bus.pc_out, bus.dest, bus.shift_operand} !== '0) begin
      errors++; $display("FAIL reset_data got rn=%h rm=%h pc=%h", bus.val_rn, bus.val_rm, bus.pc_out);
    end
    checks++;
    if (bus.bubble_cnt !== 16'd0 || bus2.bubble_cnt !== 2'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d exp 0", bus.bubble_cnt, bus2.bubble_cnt);
    end
    idle();
  endtask

  task automatic test_add();
    bus.wb_en_wb = 1'b1; bus.dest_wb = 4'd2; bus.result_wb = 32'd5;
    step();
    bus.dest_wb = 4'd3; bus.result_wb = 32'd7;
    step();
    bus.wb_en_wb = 1'b0;
    bus.instruction_in = 32'hE0821003; bus.valid_in = 1'b1; bus.pc_in = 32'h40;
    #1;
    checks++;
    if ({bus.src1, bus.src2, bus.two_src} !== {4'd2, 4'd3, 1'b1}) begin
      errors++; $display("FAIL add_comb got src1=%0d src2=%0d two=%b exp 2 3 1", bus.src1, bus.src2, bus.two_src);
    end
    step();
    checks++;
    if ({bus.valid_out, bus.exe_cmd, bus.wb_en, bus.mem_r_en, bus.mem_w_en, bus.dest} !== {1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 4'd1}) begin
      errors++; $display("FAIL add_ctrl got v=%b exe=%b wb=%b dest=%0d exp 1 0010 1 1", bus.valid_out, bus.exe_cmd, bus.wb_en, bus.dest);
    end
    checks++;
    if (bus.val_rn !== 32'd5 || bus.val_rm !== 32'd7 || bus.pc_out !== 32'h40) begin
      errors++; $display("FAIL add_data got rn=%0d rm=%0d pc=%h exp 5 7 40", bus.val_rn, bus.val_rm, bus.pc_out);
    end
    checks++;
    if (bus.bubble_cnt !== 16'd0) begin
      errors++; $display("FAIL add_cnt got %0d exp 0 (valid_in=0 is not a hazard)", bus.bubble_cnt);
    end
  endtask

  task automatic test_bypass();
    bus.wb_en_wb = 1'b1; bus.dest_wb = 4'd2; bus.result_wb = 32'h1234;
    step();
    checks++;
    if (bus.val_rn !== 32'h1234) begin
      errors++; $display("FAIL bypass got %h exp 1234", bus.val_rn);
    end
    bus.wb_en_wb = 1'b0;
    step();
    checks++;
    if (bus.val_rn !== 32'h1234) begin
      errors++; $display("FAIL bypass_written got %h exp 1234", bus.val_rn);
    end
  endtask

  task automatic test_str();
    bus.instruction_in = 32'hE5824000;
    #1;
    checks++;
    if ({bus.src2, bus.two_src} !== {4'd4, 1'b1}) begin
      errors++; $display("FAIL str_comb got src2=%0d two=%b exp 4 1", bus.src2, bus.two_src);
    end
    step();
    checks++;
    if ({bus.exe_cmd, bus.wb_en, bus.mem_r_en, bus.mem_w_en, bus.valid_out} !== {4'b0010, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL str_ctrl got exe=%b wb=%b mr=%b mw=%b exp 0010 0 0 1", bus.exe_cmd, bus.wb_en, bus.mem_r_en, bus.mem_w_en);
    end
  endtask

  task automatic test_cond_fail();
    bus.instruction_in = 32'h03A00001; bus.status_z = 1'b0;
    step();
    checks++;
    if ({bus.valid_out, bus.exe_cmd, bus.wb_en, bus.mem_r_en, bus.mem_w_en, bus.b, bus.s} !== 10'b10_0000_0000
        || bus.shift_operand !== 12'h001 || bus.imm !== 1'b1) begin
      errors++; $display("FAIL moveq_annul got v=%b exe=%b wb=%b sh=%h exp 1 0000 0 001", bus.valid_out, bus.exe_cmd, bus.wb_en, bus.shift_operand);
    end
    bus.status_z = 1'b1;
    step();
    checks++;
    if ({bus.valid_out, bus.exe_cmd, bus.wb_en} !== {1'b1, 4'b0001, 1'b1}) begin
      errors++; $display("FAIL moveq_pass got v=%b exe=%b wb=%b exp 1 0001 1", bus.valid_out, bus.exe_cmd, bus.wb_en);
    end
    bus.status_z = 1'b0;
  endtask

  task automatic test_hazard_freeze();
    bus.instruction_in = 32'hE0821003;
    step();
    bus.freeze = 1'b1; bus.instruction_in = 32'hE5824000;
    step(); step();
    checks++;
    if ({bus.valid_out, bus.exe_cmd, bus.wb_en, bus.mem_w_en, bus.dest} !== {1'b1, 4'b0010, 1'b1, 1'b0, 4'd1}) begin
      errors++; $display("FAIL freeze_hold got v=%b exe=%b wb=%b mw=%b dest=%0d exp ADD held", bus.valid_out, bus.exe_cmd, bus.wb_en, bus.mem_w_en, bus.dest);
    end
    bus.freeze = 1'b0; bus.hazard = 1'b1;
    step(); step(); step();
    checks++;
    if (bus.valid_out !== 1'b0 || bus.wb_en !== 1'b0 || bus.bubble_cnt !== 16'd3) begin
      errors++; $display("FAIL hazard got v=%b wb=%b cnt=%0d exp 0 0 3", bus.valid_out, bus.wb_en, bus.bubble_cnt);
    end
    bus.freeze = 1'b1;
    step(); step();
    checks++;
    if (bus.valid_out !== 1'b0 || bus.bubble_cnt !== 16'd3) begin
      errors++; $display("FAIL hazard_freeze got v=%b cnt=%0d exp 0 3", bus.valid_out, bus.bubble_cnt);
    end
    bus.freeze = 1'b0; bus.hazard = 1'b0;
  endtask

  task automatic test_flush_freeze();
    bus.instruction_in = 32'hE0821003;
    step();
    bus.flush = 1'b1; bus.freeze = 1'b1; bus.hazard = 1'b1;
    step();
    checks++;
    if ({bus.valid_out, bus.exe_cmd, bus.wb_en, bus.mem_r_en, bus.mem_w_en, bus.b, bus.s} !== 10'b0
        || bus.bubble_cnt !== 16'd3) begin
      errors++; $display("FAIL flush_freeze got v=%b exe=%b wb=%b cnt=%0d exp 0 0000 0 3", bus.valid_out, bus.exe_cmd, bus.wb_en, bus.bubble_cnt);
    end
    bus.flush = 1'b0; bus.freeze = 1'b0; bus.hazard = 1'b0;
  endtask

  task automatic test_pc_read();
    bus.instruction_in = 32'hE08F1003; bus.pc_in = 32'h100;
    bus.wb_en_wb = 1'b1; bus.dest_wb = 4'd15; bus.result_wb = 32'hDEAD;
    step();
    checks++;
    if (bus.val_rn !== 32'h104 || bus.pc_out !== 32'h100) begin
      errors++; $display("FAIL pc_read got rn=%h pc=%h exp 104 100", bus.val_rn, bus.pc_out);
    end
    bus.wb_en_wb = 1'b0; bus.instruction_in = 32'hE082100F; bus.pc_in = 32'h200;
    step();
    checks++;
    if (bus.val_rm !== 32'h204) begin
      errors++; $display("FAIL pc_rm got %h exp 204", bus.val_rm);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins, pc, wv, rn_v, rm_v;
    logic [3:0]  wd, a2;
    logic [8:0]  dec, e_ctrl;
    bit          wb, fz, fl, hz, vi, n, z, c, v, known;
    logic        e_valid;
    logic [31:0] e_rn, e_rm, e_pc;
    logic [23:0] e_ins;
    int          e_cnt;
    idle();
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    e_valid = 1'b0; e_ctrl = 9'b0; e_cnt = 0; known = 1'b0;
    e_rn = 32'h0; e_rm = 32'h0; e_pc = 32'h0; e_ins = 24'h0;
    for (int k = 0; k < 400; k++) begin
      ins = $urandom();
      if ($urandom_range(0, 1) == 0) ins[31:28] = 4'hE;
      pc = {$urandom_range(0, 65535), 2'b00};
      wb = ($urandom_range(0, 1) == 1); wd = 4'($urandom_range(0, 15)); wv = $urandom();
      fl = ($urandom_range(0, 15) == 0); fz = ($urandom_range(0, 7) == 0);
      hz = ($urandom_range(0, 5) == 0);  vi = ($urandom_range(0, 7) != 0);
      {n, z, c, v} = 4'($urandom_range(0, 15));
      bus.instruction_in = ins; bus.pc_in = pc; bus.valid_in = vi;
      bus.freeze = fz; bus.flush = fl; bus.hazard = hz;
      {bus.status_n, bus.status_z, bus.status_c, bus.status_v} = {n, z, c, v};
      bus.wb_en_wb = wb; bus.dest_wb = wd; bus.result_wb = wv;
      dec = m_decode(ins);
      a2 = dec[2] ? ins[15:12] : ins[3:0];
      #1;
      checks++;
      if ({bus.src1, bus.src2, bus.two_src} !== {ins[19:16], a2, (~ins[25] | dec[2])}) begin
        errors++; $display("FAIL rand_comb ins=%h got %0d %0d %b exp %0d %0d %b", ins, bus.src1, bus.src2, bus.two_src, ins[19:16], a2, (~ins[25] | dec[2]));
      end
      rn_v = m_read(ins[19:16], pc, wb, wd, wv);
      rm_v = m_read(a2, pc, wb, wd, wv);
      if (fl) begin
        e_valid = 1'b0; e_ctrl = 9'b0; known = 1'b0;
      end else if (!fz) begin
        if (hz || !vi) begin
          e_valid = 1'b0; e_ctrl = 9'b0; known = 1'b0;
          if (hz && e_cnt < 65535) e_cnt++;
        end else begin
          e_valid = 1'b1; known = 1'b1;
          e_ctrl = m_cond(ins[31:28], n, z, c, v) ? dec : 9'b0;
          e_rn = rn_v; e_rm = rm_v; e_pc = pc; e_ins = {ins[25], ins[15:12], ins[11:0], 7'b0};
          e_ins = ins[23:0];
        end
      end
      step();
      if (wb && wd != 4'd15) m_regs[wd] = wv;
      checks++;
      if ({bus.valid_out, bus.exe_cmd, bus.wb_en, bus.mem_r_en, bus.mem_w_en, bus.b, bus.s} !== {e_valid, e_ctrl}
          || bus.bubble_cnt !== 16'(e_cnt)) begin
        errors++; $display("FAIL rand_ctrl cyc=%0d ins=%h got %b cnt=%0d exp %b cnt=%0d", k, ins,
                           {bus.valid_out, bus.exe_cmd, bus.wb_en, bus.mem_r_en, bus.mem_w_en, bus.b, bus.s}, bus.bubble_cnt, {e_valid, e_ctrl}, e_cnt);
      end
      if (known) begin
        checks++;
        if (bus.val_rn !== e_rn || bus.val_rm !== e_rm || bus.pc_out !== e_pc
            || bus.signed_imm_24 !== e_ins || bus.shift_operand !== e_ins[11:0] || bus.dest !== e_ins[15:12]) begin
          errors++; $display("FAIL rand_data cyc=%0d got rn=%h rm=%h pc=%h si=%h exp rn=%h rm=%h pc=%h si=%h", k,
                             bus.val_rn, bus.val_rm, bus.pc_out, bus.signed_imm_24, e_rn, e_rm, e_pc, e_ins);
        end
      end
    end
    idle();
  endtask

  task automatic test_saturate();
    bus2.hazard = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (bus2.bubble_cnt !== 2'd3) begin
      errors++; $display("FAIL sat_cnt got %0d exp 3", bus2.bubble_cnt);
    end
    step();
    checks++;
    if (bus2.bubble_cnt !== 2'd3) begin
      errors++; $display("FAIL sat_nowrap got %0d exp 3", bus2.bubble_cnt);
    end
    bus2.hazard = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    test_reset();
    test_add();
    test_bypass();
    test_str();
    test_cond_fail();
    test_hazard_freeze();
    test_flush_freeze();
    test_pc_read();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
- Parametrised decode stage for the ARM pipeline: decode, condition check, register file and the ID/EXE pipeline register in one block.
- New over the previous decode stage:
  - registered outputs with freeze and flush;
  - write-through register-file bypass;
  - R15 read returns PC+8;
  - saturating bubble counter for performance monitoring.
- Sits between the IF/ID register and the EXE stage.
- Also feeds the hazard-detect unit combinationally.

Parameters:
- DATA_W, 32, datapath and register width.
- RADDR_W, 4, register address width; 2**RADDR_W architectural registers, the highest index is the PC alias.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- instruction_in  in  32  instruction from IF/ID register.
- pc_in  in  DATA_W  PC+4 of instruction_in.
- valid_in  in  1  instruction_in is a real instruction.
- freeze  in  1  hold all ID/EXE outputs (downstream stall).
- flush  in  1  squash the captured instruction (taken branch).
- hazard  in  1  data hazard; insert bubble.
- status_n, status_z, status_c, status_v  in  1 each  status register flags.
- wb_en_wb  in  1  write-back enable.
- dest_wb  in  RADDR_W  write-back register.
- result_wb  in  DATA_W  write-back data.
- src1  out  RADDR_W  combinational, instruction_in[19:16].
- src2  out  RADDR_W  combinational; instruction_in[15:12] if decoded mem_w_en, else instruction_in[3:0].
- two_src  out  1  combinational; ~instruction_in[25] | decoded mem_w_en.
- valid_out, wb_en, mem_r_en, mem_w_en, b, s  out  1 each  registered.
- exe_cmd  out  4  registered.
- val_rn, val_rm  out  DATA_W  registered.
- imm  out  1  registered.
- shift_operand  out  12  registered.
- signed_imm_24  out  24  registered.
- dest  out  RADDR_W  registered.
- pc_out  out  DATA_W  registered.
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. All state changes on the rising clk edge.
- Reset:
  - all registered outputs 0;
  - bubble_cnt 0;
  - all register-file entries 0.
- Decode:
  - uses existing ControlUnit mapping, with opcode = instruction_in[24:21], mode = instruction_in[27:26], S = instruction_in[20];
  - ADD=0010, SUB/CMP=0100, MOV=0001, AND/TST=0110, LDR/STR=0010.
- Condition check: uses existing Condition_Check on instruction_in[31:28] and the status flags.
- Register file:
  - write at clk edge when wb_en_wb and dest_wb != 2**RADDR_W-1; writes to the PC index are ignored;
  - read is combinational;
  - if the read address equals dest_wb and wb_en_wb=1, result_wb is returned (bypass);
  - reading the PC index returns pc_in+4 (PC+8);
  - src2 selects the Rm port address.
- Per-edge update priority, highest first:
  1. rst: apply reset values.
  2. flush=1: valid_out and all control outputs (wb_en, mem_r_en, mem_w_en, b, s, exe_cmd) are 0; data fields don't care. Flush overrides freeze.
  3. freeze=1: every registered output holds its value; bubble_cnt holds.
  4. hazard=1 or valid_in=0: bubble. Control outputs 0, valid_out 0. bubble_cnt increments only when hazard=1.
  5. Condition fails: control outputs 0, valid_out=1, data fields captured (annulled instruction, not a bubble).
  6. Otherwise: capture all decoded fields, with valid_out=1.
- Field extraction:
  - imm = [25];
  - shift_operand = [11:0];
  - signed_imm_24 = [23:0];
  - dest = [15:12];
  - pc_out = pc_in.
- Latency: 1 cycle from instruction_in to registered outputs.
- Combinational outputs: src1, src2 and two_src do not depend on freeze, flush or hazard.
- bubble_cnt saturates at all-ones; it does not wrap.
- Simultaneous write-back and read of the same register: the bypass value is used, and the register file is also updated at that edge.
- rst asserted mid-stall: reset wins.

Test Plan:
- Reset, then ADD R1,R2,R3 (0xE0821003), R2=5, R3=7 preloaded via write-back, valid_in=1 → next cycle:
  - exe_cmd=0010, wb_en=1, val_rn=5, val_rm=7, dest=1, valid_out=1;
  - combinationally src1=2, src2=3, two_src=1.
- Bypass: wb_en_wb=1, dest_wb=2, result_wb=0x1234 in the same cycle as 0xE0821003 → val_rn=0x1234 next cycle; R2 reads 0x1234 afterwards.
- STR R4,[R2] (0xE5824000) → src2=4, two_src=1, mem_w_en=1, exe_cmd=0010, wb_en=0.
- MOVEQ R0,#1 (0x03A00001), status_z=0 → control outputs all 0, valid_out=1, shift_operand=0x001.
- Hazard for 3 cycles, then freeze 2 cycles with hazard=1 → bubble_cnt=3, outputs held during freeze.
- Flush and freeze together → valid_out=0.
- Write-back to the PC index is ignored; reading R15 with pc_in=0x100 gives 0x104.
- CNT_W=2: 5 hazard cycles → bubble_cnt=3 (saturated).
